// File: rtl/io_interrupt_ctrl.sv
// rtl/io_interrupt_ctrl.sv - INPR/OUTR buffers, FGI/FGO flags, R flip-flop and interrupt-cycle sequencer
module io_interrupt_ctrl #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ien,
  input  logic          instr_busy,
  input  logic          instr_done,
  input  logic          inp_rd,
  input  logic          out_wr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic          out_ack,
  output logic          in_ready,
  output logic [DW-1:0] inpr,
  output logic [DW-1:0] outr,
  output logic          out_valid,
  output logic          fgi,
  output logic          fgo,
  output logic          irq_r,
  output logic          icyc_busy,
  output logic          ic_save,
  output logic          ic_write,
  output logic          ic_vec,
  output logic          ien_clr,
  output logic          out_drop
);

  typedef enum logic [1:0] {IDLE, IC0, IC1, IC2} state_t;
  state_t state;

  assign in_ready  = ~fgi;
  assign out_valid = ~fgo;

  // A device write is only accepted while FGI is clear, so a same-cycle read wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fgi  <= 1'b0;
      inpr <= '0;
    end else if (in_valid && !fgi) begin
      fgi  <= 1'b1;
      inpr <= in_data;
    end else if (inp_rd) begin
      fgi  <= 1'b0;
    end
  end

  // With FGO clear an ack takes priority and any concurrent write is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fgo      <= 1'b1;
      outr     <= '0;
      out_drop <= 1'b0;
    end else begin
      out_drop <= out_wr && !fgo;
      if (fgo) begin
        if (out_wr) begin
          outr <= cpu_wdata;
          fgo  <= 1'b0;
        end
      end else if (out_ack) begin
        fgo <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_r <= 1'b0;
    end else if (state == IC2) begin
      irq_r <= 1'b0;
    end else if (ien && (fgi || fgo) && instr_busy && state == IDLE && !irq_r) begin
      irq_r <= 1'b1;
    end
  end

  // Strobes are registered alongside the state so each is a clean one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      icyc_busy <= 1'b0;
      ic_save   <= 1'b0;
      ic_write  <= 1'b0;
      ic_vec    <= 1'b0;
      ien_clr   <= 1'b0;
    end else begin
      ic_save  <= 1'b0;
      ic_write <= 1'b0;
      ic_vec   <= 1'b0;
      ien_clr  <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_done && irq_r) begin
            state     <= IC0;
            icyc_busy <= 1'b1;
            ic_save   <= 1'b1;
          end
        end
        IC0: begin
          state    <= IC1;
          ic_write <= 1'b1;
        end
        IC1: begin
          state   <= IC2;
          ic_vec  <= 1'b1;
          ien_clr <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          icyc_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_interrupt_ctrl.sv
// tb/tb_io_interrupt_ctrl.sv - directed bench with per-cycle behavioural model compare
module tb_io_interrupt_ctrl;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ien = 1'b0, instr_busy = 1'b0, instr_done = 1'b0;
  logic          inp_rd = 1'b0, out_wr = 1'b0, in_valid = 1'b0, out_ack = 1'b0;
  logic [DW-1:0] cpu_wdata = '0, in_data = '0;
  logic          in_ready, out_valid, fgi, fgo, irq_r, icyc_busy;
  logic          ic_save, ic_write, ic_vec, ien_clr, out_drop;
  logic [DW-1:0] inpr, outr;

  int n_checks = 0;
  int n_fail = 0;

  io_interrupt_ctrl #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .ien(ien), .instr_busy(instr_busy), .instr_done(instr_done),
    .inp_rd(inp_rd), .out_wr(out_wr), .cpu_wdata(cpu_wdata), .in_data(in_data),
    .in_valid(in_valid), .out_ack(out_ack), .in_ready(in_ready), .inpr(inpr), .outr(outr),
    .out_valid(out_valid), .fgi(fgi), .fgo(fgo), .irq_r(irq_r), .icyc_busy(icyc_busy),
    .ic_save(ic_save), .ic_write(ic_write), .ic_vec(ic_vec), .ien_clr(ien_clr),
    .out_drop(out_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: flags as booleans, interrupt cycle as a step counter (-1 = not in a cycle).
  logic          m_fgi = 1'b0, m_fgo = 1'b1, m_r = 1'b0, m_drop = 1'b0;
  logic [DW-1:0] m_inpr = '0, m_outr = '0;
  int            m_step = -1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fgi <= 1'b0; m_fgo <= 1'b1; m_r <= 1'b0; m_drop <= 1'b0;
      m_inpr <= '0; m_outr <= '0; m_step <= -1;
    end else begin
      if (in_valid && !m_fgi) begin
        m_fgi <= 1'b1;
        m_inpr <= in_data;
      end else if (inp_rd && m_fgi) begin
        m_fgi <= 1'b0;
      end
      m_drop <= out_wr && !m_fgo;
      if (m_fgo && out_wr) begin
        m_fgo <= 1'b0;
        m_outr <= cpu_wdata;
      end else if (!m_fgo && out_ack) begin
        m_fgo <= 1'b1;
      end
      if (m_step == 2) m_r <= 1'b0;
      else if (m_step < 0 && ien && instr_busy && (m_fgi || m_fgo)) m_r <= 1'b1;
      if (m_step >= 0) m_step <= (m_step == 2) ? -1 : m_step + 1;
      else if (instr_done && m_r) m_step <= 0;
    end
  end

  always @(negedge clk) begin
    check("in_ready", in_ready, !m_fgi);
    check("out_valid", out_valid, !m_fgo);
    check("fgi", fgi, m_fgi);
    check("fgo", fgo, m_fgo);
    check("inpr", inpr, m_inpr);
    check("outr", outr, m_outr);
    check("irq_r", irq_r, m_r);
    check("out_drop", out_drop, m_drop);
    check("icyc_busy", icyc_busy, m_step >= 0);
    check("ic_save", ic_save, m_step == 0);
    check("ic_write", ic_write, m_step == 1);
    check("ic_vec", ic_vec, m_step == 2);
    check("ien_clr", ien_clr, m_step == 2);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    cyc(2);
    check("rst_fgo", fgo, 1);
    check("rst_fgi", fgi, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_strobes", {icyc_busy, ic_save, ic_write, ic_vec, ien_clr, out_drop, irq_r}, 0);
    check("rst_bufs", {inpr, outr}, 0);
    rst_n = 1'b1;
    cyc(1);

    in_data = 8'hA5; in_valid = 1'b1;
    cyc(1);
    in_valid = 1'b0;
    check("in_inpr", inpr, 8'hA5);
    check("in_fgi", fgi, 1);
    check("in_ready_low", in_ready, 0);
    inp_rd = 1'b1;
    cyc(1);
    inp_rd = 1'b0;
    check("inp_rd_fgi", fgi, 0);

    out_wr = 1'b1; cpu_wdata = 8'h3C;
    cyc(1);
    check("out_outr", outr, 8'h3C);
    check("out_valid_hi", out_valid, 1);
    cpu_wdata = 8'h11;
    cyc(1);
    out_wr = 1'b0;
    check("out_drop_pulse", out_drop, 1);
    check("out_outr_kept", outr, 8'h3C);
    out_ack = 1'b1;
    cyc(1);
    out_ack = 1'b0;
    check("out_drop_end", out_drop, 0);
    check("ack_fgo", fgo, 1);

    out_wr = 1'b1; cpu_wdata = 8'h22;
    cyc(1);
    out_ack = 1'b1; cpu_wdata = 8'h99;
    cyc(1);
    out_wr = 1'b0; out_ack = 1'b0;
    check("coll_out_fgo", fgo, 1);
    check("coll_out_outr", outr, 8'h22);
    check("coll_out_drop", out_drop, 1);

    ien = 1'b1; instr_busy = 1'b1;
    cyc(1);
    check("irq_set", irq_r, 1);
    instr_done = 1'b1;
    cyc(1);
    instr_done = 1'b0;
    check("ic0_save", ic_save, 1);
    check("ic0_busy", icyc_busy, 1);
    instr_done = 1'b1;
    cyc(1);
    instr_done = 1'b0;
    check("ic1_write", ic_write, 1);
    check("ic1_save_low", ic_save, 0);
    cyc(1);
    check("ic2_vec_clr", {ic_vec, ien_clr}, 2'b11);
    check("ic2_write_low", ic_write, 0);
    cyc(1);
    check("ic_done_irq", irq_r, 0);
    check("ic_done_busy", icyc_busy, 0);
    cyc(1);
    check("irq_reset_again", irq_r, 1);
    ien = 1'b0;
    cyc(3);
    check("irq_survives_ien_drop", irq_r, 1);
    instr_done = 1'b1;
    cyc(1);
    instr_done = 1'b0;
    check("late_ic0", ic_save, 1);
    cyc(3);
    check("late_done", {irq_r, icyc_busy}, 2'b00);

    in_data = 8'h5A; in_valid = 1'b1;
    cyc(1);
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      instr_done = (i % 4 == 3);
      cyc(1);
      check("noreq_irq", irq_r, 0);
      check("noreq_busy", icyc_busy, 0);
    end
    instr_done = 1'b0;
    instr_busy = 1'b0;

    inp_rd = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    cyc(1);
    inp_rd = 1'b0;
    check("coll_in_fgi", fgi, 0);
    check("coll_in_inpr", inpr, 8'h5A);
    cyc(1);
    in_valid = 1'b0;
    check("coll_in_next", inpr, 8'h77);
    check("coll_in_fgi_set", fgi, 1);

    out_wr = 1'b1; cpu_wdata = 8'h44;
    cyc(1);
    out_wr = 1'b0;
    ien = 1'b1; instr_busy = 1'b1;
    cyc(1);
    check("pre_rst_irq", irq_r, 1);
    check("pre_rst_fgo", fgo, 0);
    ien = 1'b0; instr_busy = 1'b0; instr_done = 1'b1;
    cyc(1);
    instr_done = 1'b0;
    cyc(1);
    check("pre_rst_ic1", ic_write, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_fgo", fgo, 1);
    check("arst_fgi", fgi, 0);
    check("arst_irq", irq_r, 0);
    check("arst_busy", icyc_busy, 0);
    check("arst_strobes", {ic_write, ic_vec, ien_clr}, 0);
    #1 rst_n = 1'b1;
    cyc(3);
    check("post_rst_clr", ien_clr, 0);
    check("post_rst_busy", icyc_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_interrupt_ctrl.md
# io_interrupt_ctrl

I/O flag and interrupt-request controller for the basic-computer datapath. It owns the 8-bit input and output buffer registers (INPR/OUTR) and the device-ready flags FGI/FGO. It raises the interrupt-request flip-flop R when IEN and a flag are both set. At the instruction boundary it sequences the three-step interrupt cycle, which ends by issuing `ien_clr` back to the IEN flip-flop logic. It is the requesting end of the IEN interface: it consumes `ien` and produces the clear condition.

## Interface
- `DW`, default 8: width of the INPR/OUTR data paths.
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `ien`  in  1  current interrupt-enable flip-flop value.
- `instr_busy`  in  1  high while the CPU is in the execute phase (T3 and later).
- `instr_done`  in  1  one-cycle pulse at the end of each instruction.
- `inp_rd`  in  1  CPU INP strobe; reads INPR and clears FGI.
- `out_wr`  in  1  CPU OUT strobe; loads OUTR from `cpu_wdata` and clears FGO.
- `cpu_wdata`  in  DW  data for OUTR.
- `in_data`  in  DW  input device data.
- `in_valid`  in  1  input device offers `in_data`.
- `out_ack`  in  1  output device has consumed OUTR.
- `in_ready`  out  1  equals ~FGI.
- `inpr`  out  DW  INPR contents.
- `outr`  out  DW  OUTR contents.
- `out_valid`  out  1  OUTR holds undelivered data; equals ~FGO.
- `fgi`, `fgo`  out  1 each  flag values, used for SKI/SKO.
- `irq_r`  out  1  R flip-flop.
- `icyc_busy`  out  1  interrupt cycle in progress; CPU must not fetch.
- `ic_save`  out  1  step 0 strobe: AR<-0, TR<-PC.
- `ic_write`  out  1  step 1 strobe: M[AR]<-TR, PC<-0.
- `ic_vec`  out  1  step 2 strobe: PC<-PC+1.
- `ien_clr`  out  1  step 2 strobe: clear IEN.
- `out_drop`  out  1  one-cycle pulse when an `out_wr` is ignored.

## Operation
- FGI:
  - Set when `in_valid & in_ready`; INPR <= `in_data` in the same edge.
  - Cleared by `inp_rd`.
  - `inp_rd` while FGI=0 has no effect on FGI; INPR is unchanged.
- FGO:
  - `out_wr` while FGO=1 loads OUTR and clears FGO.
  - `out_wr` while FGO=0 is dropped: OUTR unchanged, `out_drop` pulses.
  - `out_ack` while FGO=0 sets FGO.
  - `out_ack` while FGO=1 is ignored.
- R:
  - Set when `ien & (fgi|fgo) & instr_busy & state==IDLE & ~irq_r`.
  - Cleared only in step IC2 or by reset.
  - A drop of `ien` after R is set does not cancel the pending cycle.
- FSM states: IDLE, IC0, IC1, IC2.
  - IDLE->IC0 on `instr_done & irq_r`.
  - IC0->IC1 and IC1->IC2 unconditionally.
  - IC2->IDLE, clearing R.
  - `instr_done` outside IDLE is ignored.
- Strobes:
  - `ic_save` is high in IC0 only.
  - `ic_write` is high in IC1 only.
  - `ic_vec` and `ien_clr` are high in IC2 only.
  - `icyc_busy` is high in IC0, IC1 and IC2.
  - All strobes are decoded from registered state: glitch-free, one cycle each.

## Timing
- Reset values: FGI=0, FGO=1, R=0, state IDLE, INPR=0, OUTR=0.
  - Resulting outputs: `in_ready`=1, `out_valid`=0, all strobes 0, `out_drop`=0.
- Reset asserted mid-cycle: immediate return to IDLE, R=0, no `ien_clr`; flags return to reset values.
- Device to flag: one cycle. `in_valid` sampled at edge N gives `fgi`=1 and `in_ready`=0 after edge N.
- R rises one cycle after its set condition holds.
- Interrupt cycle:
  - The `instr_done` edge enters IC0.
  - The cycle lasts exactly 3 clocks.
  - IDLE is reached on the 3rd edge after `instr_done`.
- Simultaneous events:
  - `inp_rd` and `in_valid` in the same cycle with FGI=1: read wins, FGI=0, and the device write is not accepted (`in_ready` was 0).
  - `out_ack` and `out_wr` in the same cycle with FGO=0: the ack sets FGO and the write is dropped with `out_drop`.
  - Flag-set during IC0–IC2 does not set R, even if `ien` is still high.

## Test plan
- Reset: pulse `rst_n` low asynchronously mid-IC1 -> outputs return immediately to `fgo`=1, `fgi`=0, `irq_r`=0, `icyc_busy`=0 with no clock edge.
- Input handshake: `in_data`=0xA5 with `in_valid` for 1 cycle -> `inpr`=0xA5, `fgi`=1, `in_ready`=0. Then `inp_rd` -> `fgi`=0.
- Output handshake: `out_wr` with 0x3C -> `outr`=0x3C, `out_valid`=1. Second `out_wr` with 0x11 -> `out_drop` pulses, `outr` stays 0x3C. Then `out_ack` -> `fgo`=1.
- Interrupt cycle: `ien`=1, `fgo`=1, `instr_busy`=1 -> `irq_r`=1 next cycle. Then `instr_done` -> `ic_save`, `ic_write`, `ic_vec`+`ien_clr` on 3 consecutive cycles, then `irq_r`=0 and IDLE.
- No request: `ien`=0 with `fgi`=`fgo`=1 for 20 cycles with repeated `instr_done` -> `irq_r` stays 0, no strobes.
- Collision: `inp_rd` and `in_valid` with 0x77 in the same cycle while FGI=1 -> `fgi`=0 and `inpr` unchanged. Next-cycle `in_valid` -> `inpr`=0x77.
